// File: rtl/alu_result_buffer.sv
// ALU result buffer: FWFT FIFO of ALU results with valid/ready output
// and saturating zero/carry/drop statistics.
module alu_result_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             alu_data,
  input  logic                         alu_carry,
  input  logic                         alu_zero,
  input  logic                         alu_slt,
  input  logic                         alu_valid,
  output logic [WIDTH-1:0]             res_data,
  output logic                         res_carry,
  output logic                         res_zero,
  output logic                         res_slt,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         overflow,
  output logic [CNT_W-1:0]             zero_cnt,
  output logic [CNT_W-1:0]             carry_cnt,
  output logic [CNT_W-1:0]             drop_cnt,
  input  logic                         clr_stats
);

  localparam int EW = WIDTH + 3;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [LW-1:0]    LVL_ONE = LW'(1);
  localparam logic [LW-1:0]    LVL_MAX = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] head;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;

  assign empty = (level == '0);
  assign full  = (level == LVL_MAX);
  assign push  = alu_valid & ~full;
  assign pop   = ~empty & res_ready;
  assign drop  = alu_valid & full;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {alu_slt, alu_zero, alu_carry, alu_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop) begin
        level <= level + LVL_ONE;
      end else if (pop && !push) begin
        level <= level - LVL_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      zero_cnt  <= '0;
      carry_cnt <= '0;
      drop_cnt  <= '0;
    end else if (clr_stats) begin
      overflow  <= 1'b0;
      zero_cnt  <= '0;
      carry_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (push && alu_zero && zero_cnt != CNT_MAX) begin
        zero_cnt <= zero_cnt + CNT_ONE;
      end
      if (push && alu_carry && carry_cnt != CNT_MAX) begin
        carry_cnt <= carry_cnt + CNT_ONE;
      end
      if (drop && drop_cnt != CNT_MAX) begin
        drop_cnt <= drop_cnt + CNT_ONE;
      end
    end
  end

  assign head      = empty ? '0 : mem[rd_ptr];
  assign res_valid = ~empty;
  assign {res_slt, res_zero, res_carry, res_data} = head;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed testbench for alu_result_buffer: vector table plus
// hand-written multi-cycle sequences.
module tb_alu_result_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_data;
  logic       alu_carry, alu_zero, alu_slt, alu_valid;
  logic [7:0] res_data;
  logic       res_carry, res_zero, res_slt, res_valid;
  logic       res_ready;
  logic [2:0] level;
  logic       full, overflow;
  logic [7:0] zero_cnt, carry_cnt, drop_cnt;
  logic       clr_stats;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  alu_result_buffer #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .alu_data(alu_data), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .alu_slt(alu_slt),
    .alu_valid(alu_valid),
    .res_data(res_data), .res_carry(res_carry),
    .res_zero(res_zero), .res_slt(res_slt),
    .res_valid(res_valid), .res_ready(res_ready),
    .level(level), .full(full), .overflow(overflow),
    .zero_cnt(zero_cnt), .carry_cnt(carry_cnt),
    .drop_cnt(drop_cnt), .clr_stats(clr_stats)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic [2:0] lvl;
    logic       rv;
    logic [7:0] rd;
    logic       fl;
    logic       ov;
    logic [7:0] dc;
  } vec_t;

  vec_t vt [17];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d,
                       input logic z, input logic c,
                       input logic s, input logic rdy);
    alu_valid = v;
    alu_data  = d;
    alu_zero  = z;
    alu_carry = c;
    alu_slt   = s;
    res_ready = rdy;
  endtask

  logic [7:0] q [$];
  logic [7:0] d6;
  logic       do_pop, do_push;

  initial begin
    // valid, data, ready | level, rvalid, rdata, full, ovf, drop_cnt
    vt[0]  = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 8'h11, 1'b0, 1'b0, 8'd0};
    vt[1]  = '{1'b1, 8'h22, 1'b0, 3'd2, 1'b1, 8'h11, 1'b0, 1'b0, 8'd0};
    vt[2]  = '{1'b1, 8'h33, 1'b0, 3'd3, 1'b1, 8'h11, 1'b0, 1'b0, 8'd0};
    vt[3]  = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'h22, 1'b0, 1'b0, 8'd0};
    vt[4]  = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 8'h33, 1'b0, 1'b0, 8'd0};
    vt[5]  = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vt[6]  = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vt[7]  = '{1'b1, 8'h41, 1'b0, 3'd1, 1'b1, 8'h41, 1'b0, 1'b0, 8'd0};
    vt[8]  = '{1'b1, 8'h42, 1'b0, 3'd2, 1'b1, 8'h41, 1'b0, 1'b0, 8'd0};
    vt[9]  = '{1'b1, 8'h43, 1'b0, 3'd3, 1'b1, 8'h41, 1'b0, 1'b0, 8'd0};
    vt[10] = '{1'b1, 8'h44, 1'b0, 3'd4, 1'b1, 8'h41, 1'b1, 1'b0, 8'd0};
    vt[11] = '{1'b1, 8'h45, 1'b0, 3'd4, 1'b1, 8'h41, 1'b1, 1'b1, 8'd1};
    vt[12] = '{1'b1, 8'h46, 1'b1, 3'd3, 1'b1, 8'h42, 1'b0, 1'b1, 8'd2};
    vt[13] = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'h43, 1'b0, 1'b1, 8'd2};
    vt[14] = '{1'b1, 8'h47, 1'b1, 3'd2, 1'b1, 8'h44, 1'b0, 1'b1, 8'd2};
    vt[15] = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 8'h47, 1'b0, 1'b1, 8'd2};
    vt[16] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd2};

    rst = 1'b1;
    clr_stats = 1'b0;
    drive(1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) tick();
    check("rst_level", level, 0);
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_zero_cnt", zero_cnt, 0);
    check("rst_carry_cnt", carry_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_overflow", overflow, 0);
    check("rst_full", full, 0);

    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].v, vt[i].d, 1'b0, 1'b0, 1'b0, vt[i].rdy);
      tick();
      check($sformatf("v%0d_level", i), level, vt[i].lvl);
      check($sformatf("v%0d_valid", i), res_valid, vt[i].rv);
      check($sformatf("v%0d_data", i), res_data, vt[i].rd);
      check($sformatf("v%0d_full", i), full, vt[i].fl);
      check($sformatf("v%0d_ovf", i), overflow, vt[i].ov);
      check($sformatf("v%0d_drop", i), drop_cnt, vt[i].dc);
    end

    // Flags and counter clear
    drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("flg_zero_cnt", zero_cnt, 1);
    check("flg_carry_cnt", carry_cnt, 1);
    check("flg_level", level, 2);
    check("flg_head_data", res_data, 8'h00);
    check("flg_head_zero", res_zero, 1);
    check("flg_head_carry", res_carry, 0);
    check("flg_head_slt", res_slt, 0);
    clr_stats = 1'b1;
    drive(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    clr_stats = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_zero_cnt", zero_cnt, 0);
    check("clr_carry_cnt", carry_cnt, 0);
    check("clr_drop_cnt", drop_cnt, 0);
    check("clr_overflow", overflow, 0);
    check("clr_level", level, 3);
    tick();
    check("pop_head_data", res_data, 8'hFF);
    check("pop_head_carry", res_carry, 1);
    check("pop_head_slt", res_slt, 1);
    check("pop_head_zero", res_zero, 0);
    tick();
    check("pop2_head_data", res_data, 8'h01);
    tick();
    check("drain_level", level, 0);

    // Asynchronous reset mid-stream
    drive(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mid_level_pre", level, 2);
    #2 rst = 1'b1;
    #1;
    check("mid_level", level, 0);
    check("mid_valid", res_valid, 0);
    check("mid_data", res_data, 0);
    check("mid_zero_cnt", zero_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    check("mid_level_post", level, 0);

    // Saturation and pointer wrap against a scoreboard
    q.delete();
    for (int i = 0; i < 300; i++) begin
      d6 = 8'(i) ^ 8'h5A;
      drive(1'b1, d6, 1'b1, 1'b0, 1'b0, 1'b1);
      do_pop  = (q.size() > 0);
      do_push = (q.size() < 4);
      tick();
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d6);
      check($sformatf("sat%0d_valid", i), res_valid, q.size() != 0);
      if (q.size() != 0) check($sformatf("sat%0d_data", i), res_data, q[0]);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("sat_level", level, 0);
    check("sat_zero_cnt", zero_cnt, 255);
    check("sat_carry_cnt", carry_cnt, 0);
    check("sat_drop_cnt", drop_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
